alu_operand_sequencer: RTL and testbench

- Upstream stage of the 3-bit signed ALU/7-segment display block.
- Collects operand A, operand B and the operation select from a shared switch field over three steps. Each step is committed by the enter switch.
- Then presents the full operation to the ALU with a valid/ready handshake.
- Provides step status for LEDs and a sticky timeout error.

---
 rtl/alu_operand_sequencer_if.sv | 25 ++
 rtl/alu_operand_sequencer.sv | 102 ++++++++++
 tb/tb_alu_operand_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// alu_operand_sequencer_if: switch inputs, ALU handshake and status outputs of the operand sequencer
interface alu_operand_sequencer_if #(
  parameter int NBITS_OP  = 3,
  parameter int NBITS_SEL = 2
);
  logic [NBITS_OP-1:0]  swi_data;
  logic [NBITS_SEL-1:0] swi_sel;
  logic                 enter;
  logic                 alu_ready;
  logic [NBITS_OP-1:0]  alu_result;
  logic [NBITS_OP-1:0]  op_a;
  logic [NBITS_OP-1:0]  op_b;
  logic [NBITS_SEL-1:0] op_sel;
  logic                 op_valid;
  logic [1:0]           step;
  logic                 timeout_err;
  modport master (
    output swi_data, swi_sel, enter, alu_ready, alu_result,
    input  op_a, op_b, op_sel, op_valid, step, timeout_err
  );
  modport slave (
    input  swi_data, swi_sel, enter, alu_ready, alu_result,
    output op_a, op_b, op_sel, op_valid, step, timeout_err
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects A, B and op from switches over three enter steps, then issues to the ALU.
// Optional accumulator chaining when CHAIN_ACC_EN is defined.
module alu_operand_sequencer #(
  parameter int NBITS_OP      = 3,
  parameter int NBITS_SEL     = 2,
  parameter int ISSUE_TIMEOUT = 15
) (
  input logic                  clk_2,
  input logic                  reset,
  alu_operand_sequencer_if.slave bus
);
  localparam int CW = $clog2(ISSUE_TIMEOUT + 1);
  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10, S_ISSUE = 2'b11} state_t;
  state_t               state_q, state_d;
  logic [2:0]           sync_q, sync_d;
  logic [NBITS_OP-1:0]  a_q, a_d, b_q, b_d;
  logic [NBITS_SEL-1:0] sel_q, sel_d;
  logic                 valid_q, valid_d, err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pulse;
`ifndef CHAIN_ACC_EN
  logic                 unused_result;
  assign unused_result = ^bus.alu_result;
`endif
  assign sync_d = {sync_q[1:0], bus.enter};
  assign pulse  = sync_q[1] & ~sync_q[2];
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_A: if (pulse) begin
        a_d     = bus.swi_data;
        err_d   = 1'b0;
        state_d = S_B;
      end
      S_B: if (pulse) begin
`ifdef CHAIN_ACC_EN
        // data 0 with SUB selected ends the chain without capturing
        if (bus.swi_sel == 2'b11 && bus.swi_data == '0) state_d = S_A;
        else begin
          b_d     = bus.swi_data;
          state_d = S_OP;
        end
`else
        b_d     = bus.swi_data;
        state_d = S_OP;
`endif
      end
      S_OP: if (pulse) begin
        sel_d   = bus.swi_sel;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = S_ISSUE;
      end
      default: if (bus.alu_ready) begin
        valid_d = 1'b0;
`ifdef CHAIN_ACC_EN
        a_d     = bus.alu_result;
        state_d = S_B;
`else
        state_d = S_A;
`endif
      end else if (cnt_q == CW'(ISSUE_TIMEOUT - 1)) begin
        valid_d = 1'b0;
        err_d   = 1'b1;
        state_d = S_A;
      end else cnt_d = cnt_q + 1'b1;
    endcase
  end
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= S_A;
      sync_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.op_a        = a_q;
  assign bus.op_b        = b_q;
  assign bus.op_sel      = sel_q;
  assign bus.op_valid    = valid_q;
  assign bus.step        = state_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: scoreboard bench for the operand sequencer; also exercises CHAIN_ACC_EN when defined.
module tb_alu_operand_sequencer;
`ifdef CHAIN_ACC_EN
  localparam bit CH = 1'b1;
`else
  localparam bit CH = 1'b0;
`endif
  localparam logic [2:0] RES = 3'b010;
  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  alu_operand_sequencer_if bus ();
  alu_operand_sequencer dut (.clk_2(clk_2), .reset(reset), .bus(bus));
  always #5 clk_2 = ~clk_2;

  task automatic enter_val(input logic [2:0] d, input logic [1:0] s);
    @(negedge clk_2);
    bus.swi_data = d;
    bus.swi_sel  = s;
    bus.enter    = 1'b1;
    repeat (3) @(negedge clk_2);
    bus.enter = 1'b0;
    repeat (2) @(negedge clk_2);
  endtask

  task automatic start_op(input logic [1:0] s);
    int i;
    @(negedge clk_2);
    bus.swi_sel = s;
    bus.enter   = 1'b1;
    for (i = 0; i < 8 && !bus.op_valid; i++) @(negedge clk_2);
    bus.enter = 1'b0;
    checks++;
    if (i !== 3) begin errors++; $display("FAIL valid_latency: got %0d negedges, expected 3", i); end
    checks++;
    if (bus.step !== 2'b11) begin errors++; $display("FAIL step_issue: got %b, expected 11", bus.step); end
  endtask

  task automatic issue(input logic [1:0] s, input int ready_at, input bit tog, input int exp_n, input bit exp_err);
    int n;
    logic [7:0] e;
    logic hs;
    hs = 1'b0;
    e  = '0;
    start_op(s);
    n = 0;
    while (bus.op_valid && n < 40) begin
      n++;
      bus.alu_ready = (n == ready_at);
      if (tog) bus.enter = (n == 1);
      if (n == ready_at) begin
        hs = 1'b1;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL sb_empty: handshake with no expected entry"); end
        else begin
          e = sb.pop_front();
          if ({2'b00, bus.op_a, bus.op_b, bus.op_sel} !== e) begin
            errors++;
            $display("FAIL handshake_ops: got a=%b b=%b sel=%b, expected a=%b b=%b sel=%b",
                     bus.op_a, bus.op_b, bus.op_sel, e[7:5], e[4:2], e[1:0]);
          end
        end
      end
      @(negedge clk_2);
    end
    bus.alu_ready = 1'b0;
    bus.enter     = 1'b0;
    checks++;
    if (n !== exp_n) begin errors++; $display("FAIL valid_cycles: got %0d, expected %0d", n, exp_n); end
    checks++;
    if (bus.timeout_err !== exp_err) begin errors++; $display("FAIL timeout_err: got %b, expected %b", bus.timeout_err, exp_err); end
    checks++;
    if (bus.step !== ((hs && CH) ? 2'b01 : 2'b00)) begin
      errors++; $display("FAIL step_after_issue: got %b, expected %b", bus.step, (hs && CH) ? 2'b01 : 2'b00);
    end
    if (hs) begin
      checks++;
      if (bus.op_a !== (CH ? RES : e[7:5])) begin
        errors++; $display("FAIL op_a_after: got %b, expected %b", bus.op_a, CH ? RES : e[7:5]);
      end
    end
  endtask

  task automatic leave_chain();
    if (CH && bus.step == 2'b01) enter_val(3'b000, 2'b11);
  endtask

  task automatic test_reset();
    bus.swi_data = '0; bus.swi_sel = '0; bus.enter = 1'b0; bus.alu_ready = 1'b0; bus.alu_result = RES;
    repeat (2) @(negedge clk_2);
    checks++;
    if ({bus.op_a, bus.op_b, bus.op_sel, bus.op_valid, bus.step, bus.timeout_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got a=%b b=%b sel=%b v=%b step=%b err=%b, expected all 0",
               bus.op_a, bus.op_b, bus.op_sel, bus.op_valid, bus.step, bus.timeout_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    enter_val(3'b011, 2'b00);
    checks++;
    if (bus.step !== 2'b01 || bus.op_a !== 3'b011) begin errors++; $display("FAIL step_a: got step=%b a=%b, expected 01 011", bus.step, bus.op_a); end
    enter_val(3'b110, 2'b00);
    checks++;
    if (bus.step !== 2'b10 || bus.op_b !== 3'b110) begin errors++; $display("FAIL step_b: got step=%b b=%b, expected 10 110", bus.step, bus.op_b); end
    sb.push_back({2'b00, 3'b011, 3'b110, 2'b10});
    issue(2'b10, 1, 1'b0, 1, 1'b0);
    leave_chain();
  endtask

  task automatic test_ready_late();
    enter_val(3'b011, 2'b00);
    enter_val(3'b110, 2'b00);
    sb.push_back({2'b00, 3'b011, 3'b110, 2'b01});
    issue(2'b01, 4, 1'b1, 4, 1'b0);
    repeat (4) @(negedge clk_2);
    checks++;
    if (bus.step !== (CH ? 2'b01 : 2'b00) || bus.op_b !== 3'b110) begin
      errors++; $display("FAIL enter_in_issue: got step=%b b=%b, expected step=%b b=110", bus.step, bus.op_b, CH ? 2'b01 : 2'b00);
    end
    leave_chain();
  endtask

  task automatic test_timeout();
    enter_val(3'b101, 2'b00);
    enter_val(3'b001, 2'b00);
    issue(2'b11, 0, 1'b0, 15, 1'b1);
    checks++;
    if (bus.op_a !== 3'b101 || bus.op_b !== 3'b001 || bus.op_sel !== 2'b11) begin
      errors++; $display("FAIL timeout_hold: got a=%b b=%b sel=%b, expected 101 001 11", bus.op_a, bus.op_b, bus.op_sel);
    end
    enter_val(3'b111, 2'b00);
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.step !== 2'b01) begin
      errors++; $display("FAIL err_clear: got err=%b step=%b, expected 0 01", bus.timeout_err, bus.step);
    end
    enter_val(3'b100, 2'b00);
    sb.push_back({2'b00, 3'b111, 3'b100, 2'b00});
    issue(2'b00, 15, 1'b0, 15, 1'b0);
    leave_chain();
  endtask

  task automatic test_hold_and_reset();
    @(negedge clk_2);
    bus.swi_data = 3'b101;
    bus.enter    = 1'b1;
    repeat (4) @(negedge clk_2);
    bus.swi_data = 3'b010;
    repeat (46) @(negedge clk_2);
    bus.enter = 1'b0;
    repeat (3) @(negedge clk_2);
    checks++;
    if (bus.step !== 2'b01 || bus.op_a !== 3'b101 || bus.op_b === 3'b010) begin
      errors++; $display("FAIL enter_hold: got step=%b a=%b b=%b, expected step=01 a=101 b!=010", bus.step, bus.op_a, bus.op_b);
    end
    enter_val(3'b011, 2'b00);
    start_op(2'b10);
    @(negedge clk_2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.op_valid !== 1'b0 || bus.step !== 2'b00 || bus.op_a !== 3'b000) begin
      errors++; $display("FAIL async_reset: got v=%b step=%b a=%b, expected 0 00 000", bus.op_valid, bus.step, bus.op_a);
    end
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic test_chain();
    enter_val(3'b001, 2'b00);
    enter_val(3'b001, 2'b00);
    sb.push_back({2'b00, 3'b001, 3'b001, 2'b10});
    issue(2'b10, 1, 1'b0, 1, 1'b0);
    if (CH) begin
      enter_val(3'b001, 2'b00);
      sb.push_back({2'b00, RES, 3'b001, 2'b10});
      issue(2'b10, 2, 1'b0, 2, 1'b0);
      enter_val(3'b000, 2'b11);
      checks++;
      if (bus.step !== 2'b00 || bus.op_b !== 3'b001) begin
        errors++; $display("FAIL chain_break: got step=%b b=%b, expected 00 001", bus.step, bus.op_b);
      end
    end else begin
      enter_val(3'b001, 2'b00);
      enter_val(3'b000, 2'b11);
      checks++;
      if (bus.step !== 2'b10 || bus.op_b !== 3'b000) begin
        errors++; $display("FAIL no_break: got step=%b b=%b, expected 10 000", bus.step, bus.op_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_late();
    test_timeout();
    test_hold_and_reset();
    test_chain();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
